// File: rtl/ex_mem_elastic_reg.sv
// ex_mem_elastic_reg
//   EX/MEM pipeline stage with a valid/ready handshake. It holds up to two
//   instructions: a main output register that feeds MEM and one skid entry.
//   in_ready is a flop output, so a MEM stall never creates a combinational
//   path back into EX. Flush turns every held entry into a bubble. A
//   saturating counter records how many cycles MEM held off a valid entry.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               kill held and incoming entries this cycle
//   in_valid/in_ready   upstream handshake (in_ready == !skid_valid)
//   *_ex                instruction fields presented by EX
//   out_valid/out_ready downstream handshake
//   *_mem               main register contents; these are bubbles while out_valid=0
//   bp_cycles           saturating count of cycles with out_valid && !out_ready

module ex_mem_elastic_reg #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  alu_result_ex,
  input  logic [XLEN-1:0]  rs2_data_ex,
  input  logic [RD_W-1:0]  rd_ex,
  input  logic             mem_write_ex,
  input  logic             mem_read_ex,
  input  logic             wb_reg_file_ex,
  input  logic             memtoreg_ex,
  input  logic [2:0]       mem_load_type_ex,
  input  logic [1:0]       mem_store_type_ex,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_result_mem,
  output logic [XLEN-1:0]  rs2_data_mem,
  output logic [RD_W-1:0]  rd_mem,
  output logic             mem_write_mem,
  output logic             mem_read_mem,
  output logic [2:0]       mem_load_type_mem,
  output logic [1:0]       mem_store_type_mem,
  output logic             wb_reg_file_mem,
  output logic             memtoreg_mem,
  output logic [CNT_W-1:0] bp_cycles
);

  // The encoding is {out_valid, skid_valid}, so both flags are plain flop bits.
  // 2'b01 is illegal and never reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  // rd and the control bits travel together. Data words are kept separately
  // because flush leaves them untouched.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            mem_write;
    logic            mem_read;
    logic [2:0]      load_type;
    logic [1:0]      store_type;
    logic            wb_reg_file;
    logic            memtoreg;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{
    rd:          '0,
    mem_write:   1'b0,
    mem_read:    1'b0,
    load_type:   3'b111,
    store_type:  2'b11,
    wb_reg_file: 1'b0,
    memtoreg:    1'b0
  };

  state_t state, state_next;

  ctrl_t in_ctrl, main_ctrl, skid_ctrl;
  logic [XLEN-1:0] main_alu, main_rs2, skid_alu, skid_rs2;

  logic up_xfer, down_xfer;
  logic load_main_in, load_main_skid, load_skid, clear_main, clear_skid;

  assign in_ctrl = '{
    rd:          rd_ex,
    mem_write:   mem_write_ex,
    mem_read:    mem_read_ex,
    load_type:   mem_load_type_ex,
    store_type:  mem_store_type_ex,
    wb_reg_file: wb_reg_file_ex,
    memtoreg:    memtoreg_ex
  };

  assign out_valid = state[1];
  assign in_ready  = ~state[0];
  assign up_xfer   = in_valid && in_ready;
  assign down_xfer = out_valid && out_ready;

  // Next-state and datapath steering. Flush overrides every handshake.
  // This drops a simultaneous input and makes a simultaneous out_ready moot.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            load_main_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (up_xfer && down_xfer) begin
            load_main_in = 1'b1;
          end else if (up_xfer) begin
            load_skid  = 1'b1;
            state_next = TWO;
          end else if (down_xfer) begin
            clear_main = 1'b1;
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so the only possible event is a drain.
          if (down_xfer) begin
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
            state_next     = ONE;
          end
        end
        default: begin
          clear_main = 1'b1;
          clear_skid = 1'b1;
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Main register. A vacated main reverts to bubble control bits, so MEM can
  // ignore out_valid for side effects. Its data word stays as it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_alu  <= '0;
      main_rs2  <= '0;
      main_ctrl <= BUBBLE_CTRL;
    end else if (load_main_in) begin
      main_alu  <= alu_result_ex;
      main_rs2  <= rs2_data_ex;
      main_ctrl <= in_ctrl;
    end else if (load_main_skid) begin
      main_alu  <= skid_alu;
      main_rs2  <= skid_rs2;
      main_ctrl <= skid_ctrl;
    end else if (clear_main) begin
      main_ctrl <= BUBBLE_CTRL;
    end
  end

  // The skid entry catches the instruction accepted while MEM is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_alu  <= '0;
      skid_rs2  <= '0;
      skid_ctrl <= BUBBLE_CTRL;
    end else if (load_skid) begin
      skid_alu  <= alu_result_ex;
      skid_rs2  <= rs2_data_ex;
      skid_ctrl <= in_ctrl;
    end else if (clear_skid) begin
      skid_ctrl <= BUBBLE_CTRL;
    end
  end

  // Back-pressure counter. It saturates at all-ones and survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_cycles <= '0;
    end else if (out_valid && !out_ready && !(&bp_cycles)) begin
      bp_cycles <= bp_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign alu_result_mem     = main_alu;
  assign rs2_data_mem       = main_rs2;
  assign rd_mem             = main_ctrl.rd;
  assign mem_write_mem      = main_ctrl.mem_write;
  assign mem_read_mem       = main_ctrl.mem_read;
  assign mem_load_type_mem  = main_ctrl.load_type;
  assign mem_store_type_mem = main_ctrl.store_type;
  assign wb_reg_file_mem    = main_ctrl.wb_reg_file;
  assign memtoreg_mem       = main_ctrl.memtoreg;

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// tb_ex_mem_elastic_reg
//   Directed bench for ex_mem_elastic_reg, built with a 3-bit back-pressure
//   counter so that saturation can be reached. A queue model of the stage is
//   compared against the DUT on every falling edge. Hand-computed literal
//   expectations pin the model along the way.

module tb_ex_mem_elastic_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result_ex = '0;
  logic [31:0] rs2_data_ex = '0;
  logic [4:0]  rd_ex = '0;
  logic        mem_write_ex = 1'b0;
  logic        mem_read_ex = 1'b0;
  logic        wb_reg_file_ex = 1'b0;
  logic        memtoreg_ex = 1'b0;
  logic [2:0]  mem_load_type_ex = '0;
  logic [1:0]  mem_store_type_ex = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_result_mem;
  logic [31:0] rs2_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        wb_reg_file_mem;
  logic        memtoreg_mem;
  logic [2:0]  bp_cycles;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 1'b0;

  ex_mem_elastic_reg #(.XLEN(32), .RD_W(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_ex(alu_result_ex), .rs2_data_ex(rs2_data_ex), .rd_ex(rd_ex),
    .mem_write_ex(mem_write_ex), .mem_read_ex(mem_read_ex),
    .wb_reg_file_ex(wb_reg_file_ex), .memtoreg_ex(memtoreg_ex),
    .mem_load_type_ex(mem_load_type_ex), .mem_store_type_ex(mem_store_type_ex),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_mem(alu_result_mem), .rs2_data_mem(rs2_data_mem), .rd_mem(rd_mem),
    .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
    .mem_load_type_mem(mem_load_type_mem), .mem_store_type_mem(mem_store_type_mem),
    .wb_reg_file_mem(wb_reg_file_mem), .memtoreg_mem(memtoreg_mem),
    .bp_cycles(bp_cycles)
  );

  always #5 clk = ~clk;

  // Model: a FIFO of at most two instructions. The head is what MEM sees.
  // When the FIFO is empty, MEM sees a bubble that carries the last head's data.
  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        mw;
    logic        mr;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic        wb;
    logic        m2r;
  } ent_t;

  ent_t        q[$];
  ent_t        newEnt;
  logic [31:0] mAlu, mRs2;
  int          mBp;
  bit          canTake;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mAlu = '0;
      mRs2 = '0;
      mBp  = 0;
    end else begin
      if (q.size() > 0 && !out_ready && mBp < 7) mBp++;
      if (flush) begin
        q.delete();
      end else begin
        canTake = (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && canTake) begin
          newEnt = '{alu_result_ex, rs2_data_ex, rd_ex, mem_write_ex, mem_read_ex,
                     mem_load_type_ex, mem_store_type_ex, wb_reg_file_ex, memtoreg_ex};
          q.push_back(newEnt);
        end
      end
      if (q.size() > 0) begin
        mAlu = q[0].alu;
        mRs2 = q[0].rs2;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  logic [95:0] actVec, expVec;
  always @(negedge clk) begin
    if (checkEn) begin
      actVec = {13'd0, out_valid, in_ready, alu_result_mem, rs2_data_mem, rd_mem,
                mem_write_mem, mem_read_mem, mem_load_type_mem, mem_store_type_mem,
                wb_reg_file_mem, memtoreg_mem, bp_cycles};
      if (q.size() > 0)
        expVec = {13'd0, 1'b1, q.size() < 2, q[0].alu, q[0].rs2, q[0].rd, q[0].mw, q[0].mr,
                  q[0].lt, q[0].st, q[0].wb, q[0].m2r, mBp[2:0]};
      else
        expVec = {13'd0, 1'b0, 1'b1, mAlu, mRs2, 5'd0, 1'b0, 1'b0, 3'b111, 2'b11,
                  1'b0, 1'b0, mBp[2:0]};
      checkOutput("cycle", actVec, expVec);
    end
  end

  // Drives one cycle of inputs. The non-data fields are derived from rd,
  // so each instruction is distinguishable.
  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                               input logic ordy, input logic fl);
    in_valid          = v;
    alu_result_ex     = alu;
    rs2_data_ex       = alu ^ 32'h5A5A0000;
    rd_ex             = rd;
    mem_write_ex      = rd[0];
    mem_read_ex       = rd[1];
    wb_reg_file_ex    = 1'b1;
    memtoreg_ex       = rd[2];
    mem_load_type_ex  = rd[2:0];
    mem_store_type_ex = rd[1:0];
    out_ready         = ordy;
    flush             = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkEn = 1'b1;
    doReset();
    checkOutput("rst_out_valid", 96'(out_valid), 96'd0);
    checkOutput("rst_in_ready", 96'(in_ready), 96'd1);
    checkOutput("rst_load_type", 96'(mem_load_type_mem), 96'h7);
    checkOutput("rst_store_type", 96'(mem_store_type_mem), 96'h3);
    checkOutput("rst_bp", 96'(bp_cycles), 96'd0);

    // Single instruction: it appears one cycle after acceptance, then drains.
    applyStimulus(1'b1, 32'h1234, 5'd5, 1'b1, 1'b0);
    checkOutput("single_valid", 96'(out_valid), 96'd1);
    checkOutput("single_alu", 96'(alu_result_mem), 96'h1234);
    checkOutput("single_rd", 96'(rd_mem), 96'd5);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("single_drain_valid", 96'(out_valid), 96'd0);
    checkOutput("single_drain_lt", 96'(mem_load_type_mem), 96'h7);

    // Stall: A then B fill both entries and C is held off.
    applyStimulus(1'b1, 32'hA, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 5'd2, 1'b0, 1'b0);
    checkOutput("stall_in_ready", 96'(in_ready), 96'd0);
    applyStimulus(1'b1, 32'hC, 5'd3, 1'b0, 1'b0);
    checkOutput("stall_hold_rd", 96'(rd_mem), 96'd1);
    checkOutput("stall_bp", 96'(bp_cycles), 96'd2);
    applyStimulus(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
    checkOutput("order_B_rd", 96'(rd_mem), 96'd2);
    checkOutput("order_B_in_ready", 96'(in_ready), 96'd1);
    applyStimulus(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
    checkOutput("order_C_rd", 96'(rd_mem), 96'd3);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("order_empty", 96'(out_valid), 96'd0);

    // Back-to-back stream with MEM always ready: one instruction per cycle.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 5'(i + 8), 1'b1, 1'b0);
      checkOutput("stream_alu", 96'(alu_result_mem), 96'(32'h100 + 32'(i)));
      checkOutput("stream_in_ready", 96'(in_ready), 96'd1);
    end
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("stream_bp", 96'(bp_cycles), 96'd0);

    // Flush while full, with a new instruction arriving in the same cycle.
    applyStimulus(1'b1, 32'hAAAA, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBBBB, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hCCCC, 5'd3, 1'b0, 1'b1);
    checkOutput("flush_valid", 96'(out_valid), 96'd0);
    checkOutput("flush_in_ready", 96'(in_ready), 96'd1);
    checkOutput("flush_rd", 96'(rd_mem), 96'd0);
    checkOutput("flush_mem_write", 96'(mem_write_mem), 96'd0);
    checkOutput("flush_store_type", 96'(mem_store_type_mem), 96'h3);
    checkOutput("flush_alu_kept", 96'(alu_result_mem), 96'hAAAA);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    checkOutput("flush_dropped", 96'(out_valid), 96'd0);

    // The counter saturates at 7 when MEM stalls for 10 cycles.
    doReset();
    applyStimulus(1'b1, 32'h5, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    checkOutput("bp_saturate", 96'(bp_cycles), 96'd7);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    checkOutput("bp_hold", 96'(bp_cycles), 96'd7);

    // Asynchronous reset between edges while full.
    applyStimulus(1'b1, 32'h6, 5'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 96'(out_valid), 96'd0);
    checkOutput("arst_in_ready", 96'(in_ready), 96'd1);
    checkOutput("arst_bp", 96'(bp_cycles), 96'd0);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
